pipefft_twid_loader: RTL and testbench

- Write-side master for the pipelined-FFT twiddle table RAM (16 x 64-bit, separate read/write ports).
- Accepts twiddle coefficients as a valid/ready stream of (re, im) pairs from the config/ROM path.
- Packs each pair into one 64-bit word and drives the RAM write port sequentially from address 0.
- Reports load completion so the FFT engine starts reading only from a complete table.

---
 rtl/pipefft_twid_pkg.sv | 28 ++
 rtl/pipefft_twid_pack.sv | 45 ++++
 rtl/pipefft_twid_loader.sv | 160 ++++++++++++++++
 tb/tb_pipefft_twid_loader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipefft_twid_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pipefft_twid_pkg
// Purpose  : Shared definitions for the pipelined-FFT twiddle table loader:
//            loader state encoding, default table geometry and the RAM word
//            packing helper ({im, re}).
// Revision : 1.0 - initial release
// ============================================================================
package pipefft_twid_pkg;

  localparam int TWID_DEPTH = 16;  // table entries
  localparam int TWID_AW    = 4;   // log2(TWID_DEPTH)
  localparam int TWID_DW    = 32;  // width of one twiddle component

  typedef enum logic [1:0] {
    TWID_IDLE  = 2'd0,
    TWID_LOAD  = 2'd1,
    TWID_FLUSH = 2'd2
  } twid_state_e;

  // RAM word layout: imaginary part in the upper half, real in the lower.
  function automatic logic [2*TWID_DW-1:0] twid_word(input logic [TWID_DW-1:0] re,
                                                     input logic [TWID_DW-1:0] im);
    return {im, re};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipefft_twid_pack.sv
`default_nettype none
// ============================================================================
// Module   : pipefft_twid_pack
// Purpose  : Combinational packing of one twiddle coefficient into a RAM word,
//            with an optional saturating conjugate of the imaginary part.
// Ports    : re   in  DW    real component (two's complement)
//            im   in  DW    imaginary component (two's complement)
//            conj in  1     1: store -im (saturating), 0: store im as-is
//            word out 2*DW  packed {im', re}
// Revision : 1.0 - initial release
// ============================================================================
module pipefft_twid_pack
  import pipefft_twid_pkg::*;
#(
  parameter int DW = TWID_DW
) (
  input  logic [DW-1:0]   re,
  input  logic [DW-1:0]   im,
  input  logic            conj,
  output logic [2*DW-1:0] word
);

  localparam logic [DW-1:0] c_MOST_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] c_MOST_POS = {1'b0, {(DW-1){1'b1}}};

  logic [DW-1:0] w_imNeg;
  logic [DW-1:0] w_im;

  // Negating the most-negative value would overflow back onto itself, so it
  // is clamped to the most-positive value instead.
  assign w_imNeg = (im == c_MOST_NEG) ? c_MOST_POS : -im;
  assign w_im    = conj ? w_imNeg : im;

  // The shared packing helper is fixed to the default component width; other
  // widths use the same layout spelled out directly.
  generate
    if (DW == TWID_DW) begin : g_pkgPack
      assign word = twid_word(re, w_im);
    end else begin : g_genericPack
      assign word = {w_im, re};
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pipefft_twid_loader.sv
`default_nettype none
// ============================================================================
// Module   : pipefft_twid_loader
// Purpose  : Write-side master for the pipelined-FFT twiddle table RAM.
//            Accepts (re, im) beats on a valid/ready stream, packs each into
//            one word and writes the RAM sequentially from address 0, then
//            reports whether the table was loaded completely and correctly.
// Options  : TWID_CONJ_EN - adds the conj input; when set at start the stored
//            imaginary parts are negated (saturating) for inverse FFT.
// Ports    : clk, rst           clock / synchronous active-high reset
//            start, abort       load control pulses
//            in_valid/in_ready  coefficient stream handshake
//            in_re, in_im       coefficient components
//            in_last            final beat of the upstream sequence
//            conj               conjugate enable (TWID_CONJ_EN only)
//            wD, wAddr, wEn     RAM write port ({im, re} data)
//            busy               load in progress
//            tbl_valid          table fully and correctly loaded
//            err                sticky: last load mis-sized or aborted
// Revision : 1.0 - initial release
// ============================================================================
module pipefft_twid_loader
  import pipefft_twid_pkg::*;
#(
  parameter int DEPTH = TWID_DEPTH,
  parameter int AW    = TWID_AW,
  parameter int DW    = TWID_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_re,
  input  logic [DW-1:0]   in_im,
  input  logic            in_last,
`ifdef TWID_CONJ_EN
  input  logic            conj,
`endif
  output logic [2*DW-1:0] wD,
  output logic [AW-1:0]   wAddr,
  output logic            wEn,
  output logic            busy,
  output logic            tbl_valid,
  output logic            err
);

  localparam logic [1:0]    c_IDLE      = TWID_IDLE;
  localparam logic [1:0]    c_LOAD      = TWID_LOAD;
  localparam logic [1:0]    c_FLUSH     = TWID_FLUSH;
  localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]      r_state;
  logic [AW-1:0]   r_count;
  logic            r_wEn;
  logic [AW-1:0]   r_wAddr;
  logic [2*DW-1:0] r_wD;
  logic            r_busy;
  logic            r_tblValid;
  logic            r_err;

  logic            w_accept;
  logic            w_atEnd;
  logic            w_conj;
  logic [2*DW-1:0] w_word;

`ifdef TWID_CONJ_EN
  logic            r_conj;
  assign w_conj = r_conj;
`else
  assign w_conj = 1'b0;
`endif

  assign in_ready = (r_state == c_LOAD);
  // A beat presented together with abort is dropped: abort outranks it.
  assign w_accept = in_ready && in_valid && !abort;
  assign w_atEnd  = (r_count == c_LAST_ADDR);

  pipefft_twid_pack #(
    .DW (DW)
  ) u_pack (
    .re   (in_re),
    .im   (in_im),
    .conj (w_conj),
    .word (w_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_count    <= '0;
      r_wEn      <= 1'b0;
      r_wAddr    <= '0;
      r_wD       <= '0;
      r_busy     <= 1'b0;
      r_tblValid <= 1'b0;
      r_err      <= 1'b0;
`ifdef TWID_CONJ_EN
      r_conj     <= 1'b0;
`endif
    end else begin
      // The write strobe lives for exactly one cycle per accepted beat.
      r_wEn <= 1'b0;
      case (r_state)
        c_IDLE: begin
          // abort is ignored here, so start wins when both arrive together.
          if (start) begin
            r_state    <= c_LOAD;
            r_count    <= '0;
            r_busy     <= 1'b1;
            r_tblValid <= 1'b0;
            r_err      <= 1'b0;
`ifdef TWID_CONJ_EN
            r_conj     <= conj;
`endif
          end
        end
        c_LOAD: begin
          if (abort) begin
            r_state <= c_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else if (w_accept) begin
            r_wEn   <= 1'b1;
            r_wAddr <= r_count;
            r_wD    <= w_word;
            // The DEPTH-th beat always ends the load, so the counter never
            // wraps; only an in_last landing exactly there is a clean load.
            if (w_atEnd || in_last) begin
              r_state <= c_FLUSH;
              r_err   <= !(w_atEnd && in_last);
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        c_FLUSH: begin
          // The final write is on the RAM port during this cycle.
          r_state    <= c_IDLE;
          r_busy     <= 1'b0;
          r_tblValid <= !r_err;
        end
        default: begin
          r_state <= c_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign wEn       = r_wEn;
  assign wAddr     = r_wAddr;
  assign wD        = r_wD;
  assign busy      = r_busy;
  assign tbl_valid = r_tblValid;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pipefft_twid_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipefft_twid_loader
// Purpose  : Self-checking bench for pipefft_twid_loader. Writes seen on the
//            RAM port are collected and compared with a table-level reference
//            model (which beats should land at which address, final flags).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipefft_twid_loader;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 32;
`ifdef TWID_CONJ_EN
  localparam bit CONJ_BUILT = 1'b1;
`else
  localparam bit CONJ_BUILT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, start, abort, in_valid, in_last, conj;
  logic [DW-1:0]   in_re, in_im;
  logic            in_ready, wEn, busy, tbl_valid, err;
  logic [2*DW-1:0] wD;
  logic [AW-1:0]   wAddr;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [DW-1:0] reA [32];
  logic [DW-1:0] imA [32];
  int            accEdge [32];

  logic [AW-1:0]   wAq [$];
  logic [2*DW-1:0] wDq [$];
  int              wCq [$];

  pipefft_twid_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
`ifdef TWID_CONJ_EN
    .conj      (conj),
`endif
    .wD        (wD),
    .wAddr     (wAddr),
    .wEn       (wEn),
    .busy      (busy),
    .tbl_valid (tbl_valid),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Write monitor: one entry per RAM write, tagged with the clock edge count.
  always @(negedge clk) begin
    if (wEn === 1'b1) begin
      wAq.push_back(wAddr);
      wDq.push_back(wD);
      wCq.push_back(cycle);
    end
  end

  // Reference for the stored imaginary part: arithmetic negation clamped to
  // the representable range when the conjugate option is in effect.
  function automatic logic [DW-1:0] expIm(input logic [DW-1:0] im, input bit cj);
    longint v;
    if (!(cj && CONJ_BUILT)) return im;
    v = -longint'($signed(im));
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    return v[DW-1:0];
  endfunction

  task automatic fillRandom();
    for (int i = 0; i < 32; i++) begin
      reA[i] = $urandom;
      imA[i] = $urandom;
    end
  endtask

  // Drive one load and check it against the model.
  // mode: 0 back-to-back, 1 valid every other cycle, 2 random valid + stray starts
  task automatic run_load(input string name, input int nBeats, input int lastIdx,
                          input int abortIdx, input int mode, input bit cj);
    int nW, idx, cyc, lastEdge, exitCycle;
    bit expErr, abortHit, timedOut, sawReady, acc;
    logic [2*DW-1:0] expWord;

    // Model: walk the offered beats until the load must end.
    nW = 0; expErr = 1'b0; abortHit = 1'b0;
    for (int i = 0; i < nBeats; i++) begin
      if (i == abortIdx) begin nW = i; expErr = 1'b1; abortHit = 1'b1; break; end
      if (i == lastIdx || i == DEPTH - 1) begin
        nW = i + 1;
        expErr = !(i == lastIdx && i == DEPTH - 1);
        break;
      end
    end

    for (int i = 0; i < 32; i++) accEdge[i] = -1;
    wAq.delete(); wDq.delete(); wCq.delete();
    @(negedge clk); start = 1'b1; conj = cj;
    @(negedge clk); start = 1'b0; conj = ~cj;  // conj must have been latched
    total++;
    if ({busy, tbl_valid, err} !== 3'b100) begin
      bad++;
      $display("FAIL %s after_start: busy/tbl_valid/err=%b required 100", name, {busy, tbl_valid, err});
    end

    idx = 0; cyc = 0; lastEdge = 0; timedOut = 1'b0; sawReady = 1'b0;
    forever begin
      if (busy !== 1'b1) break;
      if (cyc >= 300) begin timedOut = 1'b1; break; end
      in_valid = (idx < nBeats) && (mode == 0 || (mode == 1 && cyc % 2 == 0) ||
                                    (mode == 2 && $urandom_range(0, 1) == 1));
      in_re   = reA[idx % 32];
      in_im   = imA[idx % 32];
      in_last = (idx == lastIdx);
      abort   = in_valid && (idx == abortIdx);
      start   = (mode == 2) && ($urandom_range(0, 7) == 0);
      acc     = in_valid && (in_ready === 1'b1);
      if (in_ready === 1'b1 && idx >= DEPTH) sawReady = 1'b1;
      @(negedge clk); cyc++;
      if (acc && !abort) begin
        accEdge[idx] = cycle;
        lastEdge = cycle;
        idx++;
      end
    end
    in_valid = 1'b0; abort = 1'b0; in_last = 1'b0; start = 1'b0;
    exitCycle = cycle;

    total++;
    if (timedOut) begin
      bad++;
      $display("FAIL %s timeout: busy still %b after 300 cycles, required 0", name, busy);
    end
    total++;
    if (wAq.size() != nW) begin
      bad++;
      $display("FAIL %s write_count: got %0d required %0d", name, wAq.size(), nW);
    end
    for (int i = 0; i < nW && i < wAq.size(); i++) begin
      expWord = {expIm(imA[i], cj), reA[i]};
      total++;
      if (wAq[i] !== AW'(i) || wDq[i] !== expWord) begin
        bad++;
        $display("FAIL %s write%0d: addr=%0d data=%h required addr=%0d data=%h",
                 name, i, wAq[i], wDq[i], i, expWord);
      end
      total++;
      if (wCq[i] != accEdge[i]) begin
        bad++;
        $display("FAIL %s latency%0d: write at edge %0d required edge %0d", name, i, wCq[i], accEdge[i]);
      end
    end
    total++;
    if (err !== expErr || tbl_valid !== !expErr || wEn !== 1'b0) begin
      bad++;
      $display("FAIL %s final_flags: err=%b tbl_valid=%b wEn=%b required err=%b tbl_valid=%b wEn=0",
               name, err, tbl_valid, wEn, expErr, !expErr);
    end
    total++;
    if (sawReady) begin
      bad++;
      $display("FAIL %s ready_after_full: in_ready=1 after %0d accepts, required 0", name, DEPTH);
    end
    if (!abortHit && !timedOut) begin
      total++;
      if (exitCycle != lastEdge + 1) begin
        bad++;
        $display("FAIL %s busy_drop: busy low at edge %0d required edge %0d", name, exitCycle, lastEdge + 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, wEn, busy, tbl_valid, err} !== 5'b0 || wAddr !== '0 || wD !== '0) begin
      bad++;
      $display("FAIL reset: ready/wEn/busy/tv/err=%b wAddr=%0d wD=%h required all zero",
               {in_ready, wEn, busy, tbl_valid, err}, wAddr, wD);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, wEn, busy, tbl_valid, err} !== 5'b0) begin
      bad++;
      $display("FAIL reset_idle: ready/wEn/busy/tv/err=%b required 00000", {in_ready, wEn, busy, tbl_valid, err});
    end
  endtask

  task automatic test_nominal();
    for (int k = 0; k < 32; k++) begin
      reA[k] = DW'(k);
      imA[k] = DW'(32'h100 + k);
    end
    run_load("nominal", 16, 15, -1, 0, 1'b0);
    total++;
    if (wDq.size() != 16 || wDq[15] !== 64'h0000_010F_0000_000F) begin
      bad++;
      $display("FAIL nominal_word15: got %h required 0000010f0000000f", (wDq.size() > 15) ? wDq[15] : '0);
    end
    total++;
    if (wCq.size() != 16 || wCq[15] - wCq[0] != 15) begin
      bad++;
      $display("FAIL nominal_contiguous: %0d writes spanning %0d edges, required 16 over 15",
               wCq.size(), (wCq.size() > 0) ? wCq[wCq.size()-1] - wCq[0] : -1);
    end
    repeat (3) @(negedge clk);
    total++;
    if (tbl_valid !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL nominal_hold: tbl_valid=%b busy=%b required 1 0", tbl_valid, busy);
    end
  endtask

  task automatic test_abort();
    fillRandom();
    run_load("abort_at5", 16, 15, 5, 0, 1'b0);
    fillRandom();
    run_load("after_abort", 16, 15, -1, 0, 1'b0);
  endtask

  task automatic test_reset_midload();
    fillRandom();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_re = reA[i]; in_im = imA[i]; in_last = 1'b0;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, wEn, busy, tbl_valid, err} !== 5'b0 || wAddr !== '0 || wD !== '0) begin
      bad++;
      $display("FAIL reset_midload: ready/wEn/busy/tv/err=%b wAddr=%0d required all zero",
               {in_ready, wEn, busy, tbl_valid, err}, wAddr);
    end
    wAq.delete(); wDq.delete(); wCq.delete();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (wAq.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_write: %0d writes busy=%b after reset, required 0 0", wAq.size(), busy);
    end
  endtask

`ifdef TWID_CONJ_EN
  task automatic test_conj();
    fillRandom();
    imA[0] = 32'h8000_0000;
    imA[1] = 32'h0000_0005;
    imA[2] = 32'h7FFF_FFFF;
    imA[3] = 32'h0000_0000;
    run_load("conj_on", 16, 15, -1, 0, 1'b1);
    total++;
    if (wDq.size() < 2 || wDq[0] !== {32'h7FFF_FFFF, reA[0]} || wDq[1] !== {32'hFFFF_FFFB, reA[1]}) begin
      bad++;
      $display("FAIL conj_corners: w0=%h w1=%h required %h %h", (wDq.size() > 0) ? wDq[0] : '0,
               (wDq.size() > 1) ? wDq[1] : '0, {32'h7FFF_FFFF, reA[0]}, {32'hFFFF_FFFB, reA[1]});
    end
    run_load("conj_off", 16, 15, -1, 0, 1'b0);
  endtask
`endif

  task automatic test_random();
    int lastIdx, nBeats, abortIdx;
    for (int t = 0; t < 6; t++) begin
      fillRandom();
      if ($urandom_range(0, 1) == 1) begin
        lastIdx = $urandom_range(0, 15);
        nBeats  = lastIdx + 1 + $urandom_range(0, 3);
      end else begin
        lastIdx = -1;
        nBeats  = $urandom_range(16, 20);
      end
      abortIdx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
      run_load($sformatf("random%0d", t), nBeats, lastIdx, abortIdx,
               $urandom_range(0, 2), CONJ_BUILT && ($urandom_range(0, 1) == 1));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    conj = 1'b0; in_re = '0; in_im = '0;
    test_reset();
    test_nominal();
    fillRandom();
    run_load("throttled", 16, 15, -1, 1, 1'b0);
    fillRandom();
    run_load("short", 10, 9, -1, 0, 1'b0);
    fillRandom();
    run_load("long", 20, -1, -1, 0, 1'b0);
    test_abort();
    test_reset_midload();
`ifdef TWID_CONJ_EN
    test_conj();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
